// File: rtl/bouncing_sprites.sv
// Multi-sprite animation engine: sprites step on an internal frame strobe, bounce off the
// screen edges, and are rendered as registered RGB565 for the current LCD scan position.

module bouncing_sprites #(
   parameter int CLK_MHZ   = 27,
   parameter int STROBE_HZ = 30,
   parameter int N_SPRITES = 4,
   parameter int SCREEN_W  = 480,
   parameter int SCREEN_H  = 272,
   parameter int SPRITE_W  = 16,
   parameter int SPRITE_H  = 16,
   parameter int XY_W      = 9
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            pause,
   input  logic            speed_up,
   input  logic [XY_W-1:0] x,
   input  logic [XY_W-1:0] y,
   output logic [4:0]      red,
   output logic [5:0]      green,
   output logic [4:0]      blue,
   output logic            tick,
   output logic [7:0]      bounce_count
);

   localparam int PERIOD = CLK_MHZ * 1_000_000 / STROBE_HZ;
   localparam int CNT_W  = $clog2(PERIOD);

   localparam logic [XY_W:0]   LIM_X  = (XY_W+1)'(SCREEN_W - SPRITE_W);
   localparam logic [XY_W:0]   LIM_Y  = (XY_W+1)'(SCREEN_H - SPRITE_H);
   localparam logic [XY_W-1:0] EDGE_X = XY_W'(SCREEN_W - SPRITE_W);
   localparam logic [XY_W-1:0] EDGE_Y = XY_W'(SCREEN_H - SPRITE_H);
   localparam logic [XY_W:0]   SPR_W  = (XY_W+1)'(SPRITE_W);
   localparam logic [XY_W:0]   SPR_H  = (XY_W+1)'(SPRITE_H);
   localparam logic [XY_W:0]   SCR_W  = (XY_W+1)'(SCREEN_W);
   localparam logic [XY_W:0]   SCR_H  = (XY_W+1)'(SCREEN_H);

   logic [CNT_W-1:0]     strobeCnt;
   logic [XY_W-1:0]      posX [N_SPRITES];
   logic [XY_W-1:0]      posY [N_SPRITES];
   logic [XY_W-1:0]      nextX [N_SPRITES];
   logic [XY_W-1:0]      nextY [N_SPRITES];
   logic [N_SPRITES-1:0] dirRight;
   logic [N_SPRITES-1:0] dirDown;
   logic [N_SPRITES-1:0] nextRight;
   logic [N_SPRITES-1:0] nextDown;
   logic [N_SPRITES-1:0] hitWall;
   logic [XY_W:0]        step;
   logic                 moveNow;
   logic                 pixHit;
   logic [1:0]           pixIdx;

   assign step    = speed_up ? (XY_W+1)'(2) : (XY_W+1)'(1);
   assign moveNow = tick && !pause;

   // Free-running strobe; tick is registered one count early so it is high exactly while the counter sits at PERIOD-1
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         strobeCnt <= '0;
         tick      <= 1'b0;
      end else begin
         if (strobeCnt == CNT_W'(PERIOD - 1))
            strobeCnt <= '0;
         else
            strobeCnt <= strobeCnt + 1'b1;
         tick <= (strobeCnt == CNT_W'(PERIOD - 2));
      end
   end

   // Candidate positions for the next tick; sums use one extra bit so they can never wrap
   always_comb begin
      hitWall = '0;
      for (int i = 0; i < N_SPRITES; i++) begin
         nextX[i]     = posX[i];
         nextY[i]     = posY[i];
         nextRight[i] = dirRight[i];
         nextDown[i]  = dirDown[i];
         if (dirRight[i]) begin
            if (({1'b0, posX[i]} + step) > LIM_X) begin
               nextX[i]     = EDGE_X;
               nextRight[i] = 1'b0;
               hitWall[i]   = 1'b1;
            end else begin
               nextX[i] = posX[i] + step[XY_W-1:0];
            end
         end else begin
            if ({1'b0, posX[i]} < step) begin
               nextX[i]     = '0;
               nextRight[i] = 1'b1;
               hitWall[i]   = 1'b1;
            end else begin
               nextX[i] = posX[i] - step[XY_W-1:0];
            end
         end
         if (dirDown[i]) begin
            if (({1'b0, posY[i]} + step) > LIM_Y) begin
               nextY[i]    = EDGE_Y;
               nextDown[i] = 1'b0;
               hitWall[i]  = 1'b1;
            end else begin
               nextY[i] = posY[i] + step[XY_W-1:0];
            end
         end else begin
            if ({1'b0, posY[i]} < step) begin
               nextY[i]    = '0;
               nextDown[i] = 1'b1;
               hitWall[i]  = 1'b1;
            end else begin
               nextY[i] = posY[i] - step[XY_W-1:0];
            end
         end
      end
   end

   // Sprite state and the bounce event counter advance together on an unpaused tick
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N_SPRITES; i++) begin
            posX[i]     <= XY_W'(20 + 40 * i);
            posY[i]     <= XY_W'(10 + 20 * i);
            dirRight[i] <= ((i % 2) == 0);
            dirDown[i]  <= ((i % 2) == 0);
         end
         bounce_count <= 8'd0;
      end else if (moveNow) begin
         for (int i = 0; i < N_SPRITES; i++) begin
            posX[i]     <= nextX[i];
            posY[i]     <= nextY[i];
            dirRight[i] <= nextRight[i];
            dirDown[i]  <= nextDown[i];
         end
         if (|hitWall)
            bounce_count <= bounce_count + 8'd1;
      end
   end

   // Hit test scans from the highest index down so the lowest overlapping sprite wins
   always_comb begin
      pixHit = 1'b0;
      pixIdx = 2'd0;
      for (int i = N_SPRITES - 1; i >= 0; i--) begin
         if (({1'b0, x} >= {1'b0, posX[i]}) && ({1'b0, x} < ({1'b0, posX[i]} + SPR_W)) &&
             ({1'b0, y} >= {1'b0, posY[i]}) && ({1'b0, y} < ({1'b0, posY[i]} + SPR_H))) begin
            pixHit = 1'b1;
            pixIdx = i[1:0];
         end
      end
      if (({1'b0, x} >= SCR_W) || ({1'b0, y} >= SCR_H))
         pixHit = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         red   <= 5'd0;
         green <= 6'd0;
         blue  <= 5'd0;
      end else if (!pixHit) begin
         red   <= 5'd0;
         green <= 6'd0;
         blue  <= 5'd0;
      end else begin
         case (pixIdx)
            2'd0: begin red <= 5'd31; green <= 6'd0;  blue <= 5'd0;  end
            2'd1: begin red <= 5'd0;  green <= 6'd63; blue <= 5'd0;  end
            2'd2: begin red <= 5'd0;  green <= 6'd0;  blue <= 5'd31; end
            default: begin red <= 5'd31; green <= 6'd63; blue <= 5'd31; end
         endcase
      end
   end

endmodule

// File: tb/tb_bouncing_sprites.sv
// Bench for bouncing_sprites: a behavioural sprite model checked every cycle, plus
// hand-computed pixel, tick and counter expectations at key moments.

module tb_bouncing_sprites;

   localparam int N     = 2;
   localparam int SCR_W = 80;
   localparam int SCR_H = 48;
   localparam int SPR_W = 16;
   localparam int SPR_H = 16;
   localparam int PER   = 4;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       pause;
   logic       speed_up;
   logic [8:0] x;
   logic [8:0] y;
   logic [4:0] red;
   logic [5:0] green;
   logic [4:0] blue;
   logic       tick;
   logic [7:0] bounce_count;

   int errors = 0;
   int checks = 0;
   bit checkEn = 1'b0;

   int mx [N];
   int my [N];
   int mdx [N];
   int mdy [N];
   int edges;
   int tickCount;
   int bounceTicks;
   logic [4:0] eR;
   logic [5:0] eG;
   logic [4:0] eB;

   always #5 clock = ~clock;

   bouncing_sprites #(
      .CLK_MHZ(1), .STROBE_HZ(250000), .N_SPRITES(N), .SCREEN_W(SCR_W), .SCREEN_H(SCR_H),
      .SPRITE_W(SPR_W), .SPRITE_H(SPR_H), .XY_W(9)
   ) dut (
      .clock(clock), .reset_n(reset_n), .pause(pause), .speed_up(speed_up),
      .x(x), .y(y), .red(red), .green(green), .blue(blue),
      .tick(tick), .bounce_count(bounce_count)
   );

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mx[i]  = 20 + 40 * i;
         my[i]  = 10 + 20 * i;
         mdx[i] = (i % 2 == 0) ? 1 : -1;
         mdy[i] = (i % 2 == 0) ? 1 : -1;
      end
      edges       = 0;
      tickCount   = 0;
      bounceTicks = 0;
      eR = 5'd0;
      eG = 6'd0;
      eB = 5'd0;
   endtask

   function automatic int moveAxis(input int pos, inout int dir, input int step,
                                   input int lim, inout bit bounced);
      if (dir > 0) begin
         if (pos + step > lim) begin
            dir = -1;
            bounced = 1'b1;
            return lim;
         end
         return pos + step;
      end
      if (pos < step) begin
         dir = 1;
         bounced = 1'b1;
         return 0;
      end
      return pos - step;
   endfunction

   // One clock edge of the model: colour from the pre-move positions, then move on a tick
   task automatic modelStep();
      int px = int'(x);
      int py = int'(y);
      int hitIdx = -1;
      int step;
      int d;
      bit anyB = 1'b0;
      if (px < SCR_W && py < SCR_H)
         for (int i = 0; i < N; i++)
            if (hitIdx < 0 && px >= mx[i] && px < mx[i] + SPR_W && py >= my[i] && py < my[i] + SPR_H)
               hitIdx = i;
      if (hitIdx < 0) begin
         eR = 5'd0; eG = 6'd0; eB = 5'd0;
      end else begin
         case (hitIdx % 4)
            0: begin eR = 5'd31; eG = 6'd0;  eB = 5'd0;  end
            1: begin eR = 5'd0;  eG = 6'd63; eB = 5'd0;  end
            2: begin eR = 5'd0;  eG = 6'd0;  eB = 5'd31; end
            default: begin eR = 5'd31; eG = 6'd63; eB = 5'd31; end
         endcase
      end
      if (edges % PER == PER - 1) begin
         tickCount++;
         if (!pause) begin
            step = speed_up ? 2 : 1;
            for (int i = 0; i < N; i++) begin
               d = mdx[i];
               mx[i] = moveAxis(mx[i], d, step, SCR_W - SPR_W, anyB);
               mdx[i] = d;
               d = mdy[i];
               my[i] = moveAxis(my[i], d, step, SCR_H - SPR_H, anyB);
               mdy[i] = d;
            end
            if (anyB) bounceTicks++;
         end
      end
      edges++;
   endtask

   initial begin
      modelReset();
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) modelReset();
         else modelStep();
      end
   end

   // Every-cycle comparison of all outputs against the model
   initial begin
      logic [24:0] act;
      logic [24:0] want;
      forever begin
         @(negedge clock);
         if (checkEn) begin
            act  = {red, green, blue, tick, bounce_count};
            want = {eR, eG, eB, (edges % PER == PER - 1), 8'(bounceTicks % 256)};
            checks++;
            if (act !== want) begin
               errors++;
               $display("[TB] FAIL model t=%0t got rgb/tick/count=%h expected %h", $time, act, want);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic p, input logic s);
      pause    = p;
      speed_up = s;
   endtask

   task automatic waitTicks(input int target);
      int guard = 0;
      while (tickCount < target && guard < 1000) begin
         @(negedge clock);
         guard++;
      end
      checkOutput("tick_wait", int'(tickCount >= target), 1);
   endtask

   task automatic waitBounces(input int target);
      int guard = 0;
      while (bounceTicks < target && guard < 30000) begin
         @(negedge clock);
         guard++;
      end
      checkOutput("bounce_wait", int'(bounceTicks >= target), 1);
   endtask

   // Called at a negedge: drive the scan position, then check the colour one edge later
   task automatic scanPixel(input string name, input int sx, input int sy,
                            input int er, input int eg, input int eb);
      x = 9'(sx);
      y = 9'(sy);
      @(negedge clock);
      checkOutput(name, int'({red, green, blue}), (er << 11) | (eg << 5) | eb);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0);
      x = 9'd0;
      y = 9'd0;
      repeat (3) @(negedge clock);
      checkEn = 1'b1;
      checkOutput("reset_rgb", int'({red, green, blue}), 0);
      checkOutput("reset_tick", int'(tick), 0);
      checkOutput("reset_count", int'(bounce_count), 0);

      // Tick pattern over the first 20 cycles after release
      reset_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         checkOutput($sformatf("tick_cycle%0d", k + 1), int'(tick), int'((k + 1) % 4 == 0));
         @(negedge clock);
      end

      // After 8 single-pixel ticks sprite 0 sits at (28,18)
      waitTicks(8);
      scanPixel("px28_red", 28, 18, 31, 0, 0);
      scanPixel("px27_black", 27, 18, 0, 0, 0);
      checkOutput("count_t8", int'(bounce_count), 0);

      // Tick 13: sprite 0 at (33,23), sprite 1 at (47,17)
      waitTicks(13);
      scanPixel("overlap_red", 47, 23, 31, 0, 0);
      scanPixel("s1_only_green", 55, 20, 0, 63, 0);
      scanPixel("s0_corner_red", 33, 23, 31, 0, 0);
      scanPixel("s1_corner_green", 62, 32, 0, 63, 0);

      // Freeze after tick 14 for ten ticks
      applyStimulus(1'b1, 1'b0);
      waitTicks(24);
      scanPixel("paused_s0", 34, 24, 31, 0, 0);
      scanPixel("paused_left", 33, 24, 0, 0, 0);
      scanPixel("paused_s1", 46, 16, 0, 63, 0);
      applyStimulus(1'b0, 1'b0);
      waitTicks(25);
      checkOutput("count_resume", int'(bounce_count), 0);
      scanPixel("resumed_s0", 35, 25, 31, 0, 0);
      scanPixel("resumed_left", 34, 25, 0, 0, 0);

      // Double step: sprite 0 overshoots the bottom edge on tick 29 and turns back
      applyStimulus(1'b0, 1'b1);
      waitTicks(28);
      checkOutput("count_t28", int'(bounce_count), 0);
      waitTicks(29);
      checkOutput("count_t29", int'(bounce_count), 1);
      scanPixel("bottom_s0", 43, 32, 31, 0, 0);
      scanPixel("bottom_left", 42, 32, 0, 0, 0);
      waitTicks(30);
      checkOutput("count_t30", int'(bounce_count), 1);
      scanPixel("rising_s0", 45, 30, 31, 0, 0);
      scanPixel("rising_above", 45, 29, 0, 0, 0);

      // Counter wrap after 256 bounce ticks
      waitBounces(255);
      checkOutput("count_255", int'(bounce_count), 255);
      waitBounces(256);
      checkOutput("count_wrap", int'(bounce_count), 0);
      waitBounces(257);
      x = 9'(mx[0]);
      y = 9'(my[0]);
      @(negedge clock);
      checkOutput("pre_reset_red", int'(red), 31);

      // Asynchronous reset in the middle of a cycle
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_rgb", int'({red, green, blue}), 0);
      checkOutput("async_tick", int'(tick), 0);
      checkOutput("async_count", int'(bounce_count), 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      scanPixel("restart_s0", 20, 10, 31, 0, 0);
      scanPixel("restart_s1", 60, 30, 0, 63, 0);
      scanPixel("restart_left", 19, 10, 0, 0, 0);
      scanPixel("restart_s1_left", 59, 30, 0, 0, 0);
      repeat (4) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
